// File: rtl/shift_serdes_pkg.sv
// ============================================================================
// Module   : shift_serdes_pkg
// Brief    : Shared state encoding, mode/direction constants and beat helper
//            for the shift_reg_serdes lane shifter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_serdes_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHIFT_IN  = 2'd1,
    HOLD      = 2'd2,
    SHIFT_OUT = 2'd3
  } state_t;

  localparam logic MODE_SIPO = 1'b0;
  localparam logic MODE_PISO = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  function automatic int beats(input int width, input int lane);
    return width / lane;
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_reg_serdes_if.sv
// ============================================================================
// Module   : shift_reg_serdes_if
// Brief    : Control, serial and parallel handshake bundle of shift_reg_serdes.
//            SHIFT_SERDES_BITREV_EN adds the bitrev control input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface shift_reg_serdes_if #(
  parameter int WIDTH = 16,
  parameter int LANE  = 1
);
  logic             flush;
  logic             mode;
  logic             dir;
`ifdef SHIFT_SERDES_BITREV_EN
  logic             bitrev;
`endif
  logic [LANE-1:0]  s_in;
  logic             s_in_valid;
  logic             s_in_ready;
  logic [LANE-1:0]  s_out;
  logic             s_out_valid;
  logic             s_out_ready;
  logic [WIDTH-1:0] p_in;
  logic             p_in_valid;
  logic             p_in_ready;
  logic [WIDTH-1:0] p_out;
  logic             p_out_valid;
  logic             p_out_ready;
  logic             busy;

  // master drives the block (producer/consumer side), slave is the block itself
  modport master (
`ifdef SHIFT_SERDES_BITREV_EN
    output bitrev,
`endif
    output flush, mode, dir,
    output s_in, s_in_valid, s_out_ready,
    output p_in, p_in_valid, p_out_ready,
    input  s_in_ready, s_out, s_out_valid,
    input  p_in_ready, p_out, p_out_valid, busy
  );

  modport slave (
`ifdef SHIFT_SERDES_BITREV_EN
    input  bitrev,
`endif
    input  flush, mode, dir,
    input  s_in, s_in_valid, s_out_ready,
    input  p_in, p_in_valid, p_out_ready,
    output s_in_ready, s_out, s_out_valid,
    output p_in_ready, p_out, p_out_valid, busy
  );

endinterface

`default_nettype wire

// File: rtl/shift_lane_reg.sv
// ============================================================================
// Module   : shift_lane_reg
// Brief    : WIDTH-bit register moving LANE bits per beat: parallel load,
//            directional shift-in, zero-fill shift-out and synchronous clear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_lane_reg #(
  parameter int WIDTH = 16,
  parameter int LANE  = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             clear,
  input  logic             load,
  input  logic             shift_in,
  input  logic             shift_out,
  input  logic             dir,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LANE-1:0]  s_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_in_right;
  logic [WIDTH-1:0] w_in_left;
  logic [WIDTH-1:0] w_out_right;
  logic [WIDTH-1:0] w_out_left;

  // A full-width lane replaces the whole word, so there is nothing to slice.
  generate
    if (LANE == WIDTH) begin : g_single
      assign w_in_right  = s_in;
      assign w_in_left   = s_in;
      assign w_out_right = '0;
      assign w_out_left  = '0;
    end else begin : g_multi
      assign w_in_right  = {s_in, r_q[WIDTH-1:LANE]};
      assign w_in_left   = {r_q[WIDTH-LANE-1:0], s_in};
      assign w_out_right = {{LANE{1'b0}}, r_q[WIDTH-1:LANE]};
      assign w_out_left  = {r_q[WIDTH-LANE-1:0], {LANE{1'b0}}};
    end
  endgenerate

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_q <= '0;
    end else if (clear) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= load_data;
    end else if (shift_in) begin
      r_q <= dir ? w_in_left : w_in_right;
    end else if (shift_out) begin
      r_q <= dir ? w_out_left : w_out_right;
    end
  end

  assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/shift_reg_serdes.sv
// ============================================================================
// Module   : shift_reg_serdes
// Brief    : Lane shift register with SIPO/PISO conversion and valid/ready
//            handshakes. Optional macro SHIFT_SERDES_BITREV_EN adds bit-reversed
//            presentation of assembled SIPO words.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_reg_serdes
  import shift_serdes_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LANE  = 1
) (
  input  logic              clk,
  input  logic              clr,
  shift_reg_serdes_if.slave bus
);

  localparam int c_beats = beats(WIDTH, LANE);
  localparam int c_cnt_w = $clog2(c_beats) + 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_beats - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_mode;
  logic               r_dir;
  logic [WIDTH-1:0]   w_reg;
  logic               w_last;
  logic               w_clear;
  logic               w_load;
  logic               w_shift_in;
  logic               w_shift_out;
  logic               w_cfg_latch;
  logic               w_cnt_clr;
  logic               w_cnt_inc;
  logic               w_hold;

  assign w_last = (r_cnt == c_last);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_mode  <= MODE_SIPO;
      r_dir   <= DIR_RIGHT;
    end else begin
      r_state <= w_state_nxt;
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
      if (w_cfg_latch) begin
        r_mode <= bus.mode;
        r_dir  <= bus.dir;
      end
    end
  end

  // flush overrides every state and swallows any handshake on the same edge
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_load      = 1'b0;
    w_shift_in  = 1'b0;
    w_shift_out = 1'b0;
    w_cfg_latch = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    if (bus.flush) begin
      w_state_nxt = IDLE;
      w_clear     = 1'b1;
      w_cnt_clr   = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.mode == MODE_SIPO) begin
            w_state_nxt = SHIFT_IN;
            w_cfg_latch = 1'b1;
            w_clear     = 1'b1;
            w_cnt_clr   = 1'b1;
          end else if (bus.p_in_valid) begin
            w_state_nxt = SHIFT_OUT;
            w_cfg_latch = 1'b1;
            w_load      = 1'b1;
            w_cnt_clr   = 1'b1;
          end
        end
        SHIFT_IN: begin
          if (bus.s_in_valid) begin
            w_shift_in = 1'b1;
            w_cnt_inc  = 1'b1;
            if (w_last) begin
              w_state_nxt = HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.p_out_ready) begin
            w_state_nxt = IDLE;
          end
        end
        SHIFT_OUT: begin
          if (bus.s_out_ready) begin
            w_shift_out = 1'b1;
            w_cnt_inc   = 1'b1;
            if (w_last) begin
              w_state_nxt = IDLE;
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  shift_lane_reg #(
    .WIDTH (WIDTH),
    .LANE  (LANE)
  ) u_lane_reg (
    .clk       (clk),
    .clr       (clr),
    .clear     (w_clear),
    .load      (w_load),
    .shift_in  (w_shift_in),
    .shift_out (w_shift_out),
    .dir       (r_dir),
    .load_data (bus.p_in),
    .s_in      (bus.s_in),
    .q         (w_reg)
  );

  assign w_hold          = (r_state == HOLD) && (r_mode == MODE_SIPO);
  assign bus.s_in_ready  = (r_state == SHIFT_IN);
  assign bus.s_out_valid = (r_state == SHIFT_OUT);
  assign bus.p_out_valid = w_hold;
  assign bus.p_in_ready  = (r_state == IDLE) && (bus.mode == MODE_PISO) && !bus.flush;
  assign bus.busy        = (r_state != IDLE);
  assign bus.s_out       = (r_dir == DIR_LEFT) ? w_reg[WIDTH-1:WIDTH-LANE] : w_reg[LANE-1:0];

`ifdef SHIFT_SERDES_BITREV_EN
  logic             r_bitrev;
  logic [WIDTH-1:0] w_rev;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_bitrev <= 1'b0;
    end else if (w_cfg_latch) begin
      r_bitrev <= bus.bitrev;
    end
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
      assign w_rev[gi] = w_reg[WIDTH-1-gi];
    end
  endgenerate

  // Reversal only applies to the presented word; the register keeps shift order.
  assign bus.p_out = (w_hold && r_bitrev) ? w_rev : w_reg;
`else
  assign bus.p_out = w_reg;
`endif

endmodule

`default_nettype wire

// File: tb/tb_shift_reg_serdes.sv
// ============================================================================
// Module   : tb_shift_reg_serdes
// Brief    : Directed scoreboard bench for shift_reg_serdes (LANE=1 and LANE=4
//            instances, plus a WIDTH=8 instance under SHIFT_SERDES_BITREV_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_reg_serdes;

  logic clk;
  logic clr;

  int n_vec;
  int n_bad;
  int n_sb_xfer;

  logic [3:0]  exp_sb[$];
  logic [15:0] exp_pa[$];
  logic [15:0] exp_pb[$];
  logic [7:0]  exp_pc[$];

  shift_reg_serdes_if #(.WIDTH(16), .LANE(1)) ifa ();
  shift_reg_serdes_if #(.WIDTH(16), .LANE(4)) ifb ();

  shift_reg_serdes #(.WIDTH(16), .LANE(1)) u_dut_a (.clk(clk), .clr(clr), .bus(ifa));
  shift_reg_serdes #(.WIDTH(16), .LANE(4)) u_dut_b (.clk(clk), .clr(clr), .bus(ifb));

`ifdef SHIFT_SERDES_BITREV_EN
  shift_reg_serdes_if #(.WIDTH(8), .LANE(1)) ifc ();
  shift_reg_serdes #(.WIDTH(8), .LANE(1)) u_dut_c (.clk(clk), .clr(clr), .bus(ifc));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: handshake wait expired at %0t", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic s_rdy(input int which);
    case (which)
      0:       return ifa.s_in_ready;
      1:       return ifb.s_in_ready;
`ifdef SHIFT_SERDES_BITREV_EN
      2:       return ifc.s_in_ready;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic p_vld(input int which);
    case (which)
      0:       return ifa.p_out_valid;
      1:       return ifb.p_out_valid;
`ifdef SHIFT_SERDES_BITREV_EN
      2:       return ifc.p_out_valid;
`endif
      default: return 1'b0;
    endcase
  endfunction

  task automatic set_s_in(input int which, input logic [3:0] v, input logic vld);
    case (which)
      0: begin ifa.s_in = v[0]; ifa.s_in_valid = vld; end
      1: begin ifb.s_in = v;    ifb.s_in_valid = vld; end
`ifdef SHIFT_SERDES_BITREV_EN
      2: begin ifc.s_in = v[0]; ifc.s_in_valid = vld; end
`endif
      default: ;
    endcase
  endtask

  task automatic set_p_rdy(input int which, input logic r);
    case (which)
      0: ifa.p_out_ready = r;
      1: ifb.p_out_ready = r;
`ifdef SHIFT_SERDES_BITREV_EN
      2: ifc.p_out_ready = r;
`endif
      default: ;
    endcase
  endtask

  task automatic send(input int which, input logic [3:0] v);
    int k;
    set_s_in(which, v, 1'b1);
    k = 0;
    while (!s_rdy(which) && k < 20) begin
      tick();
      k++;
    end
    if (!s_rdy(which)) timeout("s_in_wait");
    tick();
    set_s_in(which, 4'h0, 1'b0);
  endtask

  task automatic take(input int which);
    int k;
    set_p_rdy(which, 1'b1);
    k = 0;
    while (!p_vld(which) && k < 20) begin
      tick();
      k++;
    end
    if (!p_vld(which)) timeout("p_out_wait");
    tick();
    set_p_rdy(which, 1'b0);
  endtask

  task automatic load_b(input logic [15:0] w);
    int k;
    ifb.p_in       = w;
    ifb.p_in_valid = 1'b1;
    k = 0;
    while (!ifb.p_in_ready && k < 20) begin
      tick();
      k++;
    end
    if (!ifb.p_in_ready) timeout("p_in_wait");
    tick();
    ifb.p_in_valid = 1'b0;
  endtask

  // Monitor: every output transfer is sampled mid-cycle, before the edge that completes it.
  always @(negedge clk) begin
    if (ifa.p_out_valid && ifa.p_out_ready) begin
      if (exp_pa.size() == 0) check("pa_unexpected", 32'(ifa.p_out), 32'hDEAD_0000);
      else check("pa_word", 32'(ifa.p_out), 32'(exp_pa.pop_front()));
    end
    if (ifb.p_out_valid && ifb.p_out_ready) begin
      if (exp_pb.size() == 0) check("pb_unexpected", 32'(ifb.p_out), 32'hDEAD_0000);
      else check("pb_word", 32'(ifb.p_out), 32'(exp_pb.pop_front()));
    end
    if (ifb.s_out_valid && ifb.s_out_ready) begin
      n_sb_xfer++;
      if (exp_sb.size() == 0) check("sb_unexpected", 32'(ifb.s_out), 32'hDEAD_0000);
      else check("sb_beat", 32'(ifb.s_out), 32'(exp_sb.pop_front()));
    end
`ifdef SHIFT_SERDES_BITREV_EN
    if (ifc.p_out_valid && ifc.p_out_ready) begin
      if (exp_pc.size() == 0) check("pc_unexpected", 32'(ifc.p_out), 32'hDEAD_0000);
      else check("pc_word", 32'(ifc.p_out), 32'(exp_pc.pop_front()));
    end
`endif
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] word;
    logic [7:0]  c_word;
    logic [3:0]  pat;
    int k;
    n_vec = 0;
    n_bad = 0;
    n_sb_xfer = 0;
    clr = 1'b1;
    ifa.flush = 0; ifa.mode = 0; ifa.dir = 0; ifa.s_in = '0; ifa.s_in_valid = 0;
    ifa.s_out_ready = 0; ifa.p_in = '0; ifa.p_in_valid = 0; ifa.p_out_ready = 0;
    ifb.flush = 0; ifb.mode = 1; ifb.dir = 1; ifb.s_in = '0; ifb.s_in_valid = 0;
    ifb.s_out_ready = 0; ifb.p_in = '0; ifb.p_in_valid = 0; ifb.p_out_ready = 0;
`ifdef SHIFT_SERDES_BITREV_EN
    ifa.bitrev = 0;
    ifb.bitrev = 0;
    ifc.bitrev = 1; ifc.flush = 0; ifc.mode = 0; ifc.dir = 0; ifc.s_in = '0; ifc.s_in_valid = 0;
    ifc.s_out_ready = 0; ifc.p_in = '0; ifc.p_in_valid = 0; ifc.p_out_ready = 0;
`endif
    repeat (2) @(posedge clk);
    #2;
    check("rst_a_flags", {ifa.s_in_ready, ifa.s_out_valid, ifa.p_out_valid, ifa.busy}, 0);
    check("rst_a_data", {ifa.p_out, 15'd0, ifa.s_out}, 0);
    check("rst_b_flags", {ifb.s_in_ready, ifb.s_out_valid, ifb.p_out_valid, ifb.busy}, 0);
    check("rst_b_data", {ifb.p_out, 12'd0, ifb.s_out}, 0);
    clr = 1'b0;

    // SIPO LSB-first, right shift: 16 bits of 0xA5C3 reassemble unchanged
    word = 16'hA5C3;
    exp_pa.push_back(16'hA5C3);
    for (int i = 0; i < 15; i++) send(0, {3'b000, word[i]});
    check("sipo_not_early", 32'(ifa.p_out_valid), 0);
    send(0, {3'b000, word[15]});
    check("sipo_valid_next", 32'(ifa.p_out_valid), 1);
    take(0);

    // PISO left shift of 0x1234: MSB nibble first
    exp_sb.push_back(4'h1); exp_sb.push_back(4'h2);
    exp_sb.push_back(4'h3); exp_sb.push_back(4'h4);
    n_sb_xfer = 0;
    load_b(16'h1234);
    ifb.s_out_ready = 1'b1;
    for (k = 0; k < 20 && ifb.busy; k++) tick();
    ifb.s_out_ready = 1'b0;
    check("piso_left_idle", 32'(ifb.busy), 0);
    check("piso_left_zero", 32'(ifb.p_out), 0);
    check("piso_left_count", n_sb_xfer, 4);

    // PISO right shift of 0xBEEF with back-pressure pattern 1-0-0-1
    ifb.dir = 1'b0;
    pat = 4'b1001;
    exp_sb.push_back(4'hF); exp_sb.push_back(4'hE);
    exp_sb.push_back(4'hE); exp_sb.push_back(4'hB);
    n_sb_xfer = 0;
    load_b(16'hBEEF);
    for (k = 0; k < 40 && ifb.busy; k++) begin
      ifb.s_out_ready = pat[k % 4];
      if (!ifb.s_out_ready && exp_sb.size() != 0) check("stall_hold", 32'(ifb.s_out), 32'(exp_sb[0]));
      tick();
    end
    ifb.s_out_ready = 1'b0;
    check("stall_count", n_sb_xfer, 4);

    // SIPO abort by flush after 2 of 4 beats, then a clean word
    ifb.mode = 1'b0;
    send(1, 4'hF);
    send(1, 4'hF);
    ifb.flush = 1'b1;
    tick();
    ifb.flush = 1'b0;
    check("flush_busy", 32'(ifb.busy), 0);
    check("flush_clear", 32'(ifb.p_out), 0);
    exp_pb.push_back(16'h4321);
    send(1, 4'h1); send(1, 4'h2); send(1, 4'h3); send(1, 4'h4);
    ifb.mode = 1'b1;
    take(1);

`ifdef SHIFT_SERDES_BITREV_EN
    // bit-reversed presentation: 0x01 assembled, shown as 0x80, then plain
    c_word = 8'h01;
    exp_pc.push_back(8'h80);
    for (int i = 0; i < 8; i++) send(2, {3'b000, c_word[i]});
    take(2);
    ifc.bitrev = 1'b0;
    exp_pc.push_back(8'h01);
    for (int i = 0; i < 8; i++) send(2, {3'b000, c_word[i]});
    take(2);
`else
    c_word = 8'h00;
`endif

    // async clear in the middle of a stalled PISO word
    ifb.dir = 1'b0;
    load_b(16'hCAFE);
    check("clr_pre_valid", {ifb.s_out_valid, ifb.s_out}, {1'b1, 4'hE});
    #1 clr = 1'b1;
    #1;
    check("clr_async_flags", {ifb.s_out_valid, ifb.p_out_valid, ifb.busy}, 0);
    check("clr_async_data", {ifb.p_out, 12'd0, ifb.s_out}, 0);
    tick();
    clr = 1'b0;
    check("clr_pin_ready_piso", 32'(ifb.p_in_ready), 1);
    ifb.mode = 1'b0;
    #1;
    check("clr_pin_ready_sipo", 32'(ifb.p_in_ready), 0);

    tick();
    check("sb_drained", exp_sb.size() + exp_pa.size() + exp_pb.size() + exp_pc.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
